// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable, coordinates, DE, active-low syncs, frame pulse.
// No flow control; the consumer samples every clk and qualifies with pixel_tick.
interface vga_timing_gen_if;
    logic       pixel_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       DE;
    logic       h_sync;
    logic       v_sync;
    logic       frame_start;

    modport master (
        output pixel_tick, x, y, DE, h_sync, v_sync, frame_start
    );

    modport slave (
        input  pixel_tick, x, y, DE, h_sync, v_sync, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: clk divider to pixel enable, h/v counters, registered DE/sync decode.
// Outputs land on the edge after pixel_tick (first (0,0) at clk CLK_DIV after reset release); no backpressure.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]        H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [9:0]       x_q, y_q, x_nxt, y_nxt;
    logic             x_wrap;
    logic             de_q, hs_q, vs_q, fs_q;
    logic             de_nxt, hs_nxt, vs_nxt;

    assign tick = (div_cnt == DIV_LAST);

    // Decode is taken from the next coordinates so the registered flags line up with x/y.
    always_comb begin
        x_wrap = (x_q == H_LAST);
        x_nxt  = x_wrap ? 10'd0 : x_q + 10'd1;
        y_nxt  = y_q;
        if (x_wrap) begin
            y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end
        de_nxt = ({1'b0, x_nxt} < 11'(H_ACTIVE)) && ({1'b0, y_nxt} < 11'(V_ACTIVE));
        hs_nxt = !(({1'b0, x_nxt} >= 11'(HS_START)) && ({1'b0, x_nxt} < 11'(HS_END)));
        vs_nxt = !(({1'b0, y_nxt} >= 11'(VS_START)) && ({1'b0, y_nxt} < 11'(VS_END)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            de_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            fs_q    <= 1'b0;
            if (tick) begin
                x_q  <= x_nxt;
                y_q  <= y_nxt;
                de_q <= de_nxt;
                hs_q <= hs_nxt;
                vs_q <= vs_nxt;
                fs_q <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
            end
        end
    end

    assign vga.pixel_tick  = tick;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.DE          = de_q;
    assign vga.h_sync      = hs_q;
    assign vga.v_sync      = vs_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three timing configurations against a closed-form raster model.
module tb_vga_timing_gen;
    typedef struct {
        int d, ha, hf, hs, hb, va, vf, vs, vb;
    } cfg_t;

    typedef struct {
        logic tick;
        int   x;
        int   y;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t e;
    } vec_t;

    cfg_t c_def = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_t c_med = '{3, 16, 2, 4, 2, 12, 2, 2, 2};
    cfg_t c_sml = '{1, 8, 1, 2, 1, 4, 1, 1, 1};

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic sb_en = 1'b0;
    int   n     = 0;
    int   tests = 0;
    int   fails = 0;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_med ();
    vga_timing_gen_if if_sml ();

    vga_timing_gen u_def (.clk(clk), .reset(reset), .vga(if_def));

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2), .CLK_DIV(3)
    ) u_med (.clk(clk), .reset(reset), .vga(if_med));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .CLK_DIV(1)
    ) u_sml (.clk(clk), .reset(reset), .vga(if_sml));

    always #5 clk = ~clk;

    // Clocks elapsed since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) n <= 0;
        else        n <= n + 1;
    end

    function automatic obs_t mk(logic t, int x, int y, logic de, logic hs, logic vs, logic fs);
        obs_t o;
        o.tick = t; o.x = x; o.y = y; o.de = de; o.hs = hs; o.vs = vs; o.fs = fs;
        return o;
    endfunction

    // Raster position as a linear pixel index: the k-th pixel step lands on index k-1 mod frame.
    function automatic obs_t model(cfg_t c, int cyc);
        int ht, vt, fr, p, x, y;
        logic t, de, hs, vs, fs;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        fr = ht * vt;
        p  = (cyc / c.d + fr - 1) % fr;
        x  = p % ht;
        y  = p / ht;
        t  = (cyc % c.d) == (c.d - 1);
        de = (x < c.ha) && (y < c.va);
        hs = !((x >= c.ha + c.hf) && (x < c.ha + c.hf + c.hs));
        vs = !((y >= c.va + c.vf) && (y < c.va + c.vf + c.vs));
        fs = (cyc >= c.d) && (cyc % c.d == 0) && (p == 0);
        return mk(t, x, y, de, hs, vs, fs);
    endfunction

    task automatic cmp(input string nm, input obs_t a, input obs_t e);
        tests++;
        if (a.tick !== e.tick || a.x != e.x || a.y != e.y || a.de !== e.de ||
            a.hs !== e.hs || a.vs !== e.vs || a.fs !== e.fs) begin
            fails++;
            $display("FAIL %s n=%0d: got tick=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b, want tick=%0b x=%0d y=%0d de=%0b hs=%0b vs=%0b fs=%0b",
                     nm, n, a.tick, a.x, a.y, a.de, a.hs, a.vs, a.fs,
                     e.tick, e.x, e.y, e.de, e.hs, e.vs, e.fs);
        end
    endtask

    task automatic cmp_int(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    function automatic obs_t get_def();
        return mk(if_def.pixel_tick, int'(if_def.x), int'(if_def.y), if_def.DE,
                  if_def.h_sync, if_def.v_sync, if_def.frame_start);
    endfunction

    function automatic obs_t get_med();
        return mk(if_med.pixel_tick, int'(if_med.x), int'(if_med.y), if_med.DE,
                  if_med.h_sync, if_med.v_sync, if_med.frame_start);
    endfunction

    function automatic obs_t get_sml();
        return mk(if_sml.pixel_tick, int'(if_sml.x), int'(if_sml.y), if_sml.DE,
                  if_sml.h_sync, if_sml.v_sync, if_sml.frame_start);
    endfunction

    always @(negedge clk) begin
        if (sb_en) begin
            cmp("sb_def", get_def(), model(c_def, n));
            cmp("sb_med", get_med(), model(c_med, n));
            cmp("sb_sml", get_sml(), model(c_sml, n));
        end
    end

    vec_t tbl[14];

    initial begin
        int guard;
        int de_cnt, vs_cnt, fs_cnt;

        tbl[0]  = '{0,    mk(0, 799, 524, 0, 1, 1, 0)};
        tbl[1]  = '{2,    mk(0, 799, 524, 0, 1, 1, 0)};
        tbl[2]  = '{3,    mk(1, 799, 524, 0, 1, 1, 0)};
        tbl[3]  = '{4,    mk(0, 0,   0,   1, 1, 1, 1)};
        tbl[4]  = '{5,    mk(0, 0,   0,   1, 1, 1, 0)};
        tbl[5]  = '{7,    mk(1, 0,   0,   1, 1, 1, 0)};
        tbl[6]  = '{8,    mk(0, 1,   0,   1, 1, 1, 0)};
        tbl[7]  = '{2560, mk(0, 639, 0,   1, 1, 1, 0)};
        tbl[8]  = '{2564, mk(0, 640, 0,   0, 1, 1, 0)};
        tbl[9]  = '{2628, mk(0, 656, 0,   0, 0, 1, 0)};
        tbl[10] = '{3011, mk(1, 751, 0,   0, 0, 1, 0)};
        tbl[11] = '{3012, mk(0, 752, 0,   0, 1, 1, 0)};
        tbl[12] = '{3200, mk(0, 799, 0,   0, 1, 1, 0)};
        tbl[13] = '{3204, mk(0, 0,   1,   1, 1, 1, 0)};

        #1 reset = 1'b0;
        sb_en = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        foreach (tbl[i]) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (n < tbl[i].cyc && guard < 10000);
            if (n != tbl[i].cyc) begin
                tests++;
                fails++;
                $display("FAIL tbl_wait[%0d]: got n=%0d, want n=%0d", i, n, tbl[i].cyc);
            end else begin
                cmp($sformatf("tbl[%0d]", i), get_def(), tbl[i].e);
            end
        end

        // Mid-frame reset on the medium raster at (10,9).
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(if_med.x == 10'd10 && if_med.y == 10'd9) && guard < 3000);
        cmp_int("mid_pos_found", (guard < 3000) ? 1 : 0, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("mid_rst_med", get_med(), mk(0, 23, 17, 0, 1, 1, 0));
        cmp("mid_rst_def", get_def(), mk(0, 799, 524, 0, 1, 1, 0));
        cmp("mid_rst_sml", get_sml(), mk(1, 11, 6, 0, 1, 1, 0));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (if_med.frame_start !== 1'b1 && guard < 100);
        cmp_int("med_first_fs_cyc", n, 3);

        // One full medium frame: n = 4 .. 1299.
        de_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        repeat (24 * 18 * 3) begin
            @(negedge clk);
            if (if_med.pixel_tick && if_med.DE) de_cnt++;
            if (if_med.pixel_tick && !if_med.v_sync) vs_cnt++;
            if (if_med.frame_start) fs_cnt++;
        end
        cmp_int("med_de_ticks", de_cnt, 16 * 12);
        cmp_int("med_vs_ticks", vs_cnt, 2 * 24);
        cmp_int("med_fs_count", fs_cnt, 1);

        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, 2500)) @(posedge clk);
            #($urandom_range(1, 4)) reset = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 4)) reset = 1'b1;
        end
        repeat (50) @(posedge clk);
        @(negedge clk);
        sb_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the VGA test-pattern colour stage and the RGB output pins.
- Divides the system clock down to a pixel-rate enable and runs horizontal/vertical counters.
- Produces pixel coordinates x/y, DE and active-low h_sync/v_sync.
- Default timing is 640x480@60 (800x525 total) from a 100 MHz clk with CLK_DIV=4.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel; legal values are 1 or more. H_TOTAL and V_TOTAL must each be 1024 or less.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- pixel_tick  output  1  one-clk pixel enable
- x  output  10  horizontal counter (0..H_TOTAL-1)
- y  output  10  vertical counter (0..V_TOTAL-1)
- DE  output  1  high when x < H_ACTIVE and y < V_ACTIVE
- h_sync  output  1  active-low horizontal sync
- v_sync  output  1  active-low vertical sync
- frame_start  output  1  one-clk pulse when counters enter (0,0)

Behaviour:
- Interface: one clock, clk. Reset port is named reset and is asynchronous, active-low. All state is on the clk rising edge or reset falling edge.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
  - HS_START = H_ACTIVE+H_FP (656), HS_END = HS_START+H_SYNC (752)
  - VS_START = V_ACTIVE+V_FP (490), VS_END = VS_START+V_SYNC (492)
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - pixel_tick = (div_cnt == CLK_DIV-1).
  - For CLK_DIV=1, pixel_tick is constantly 1 out of reset.
- Counters:
  - On a clk edge with pixel_tick=1, x increments. When x == H_TOTAL-1 it wraps to 0.
  - y increments only on the x-wrap edge. When y == V_TOTAL-1 it wraps to 0.
  - Without pixel_tick, x and y hold.
- Output registers:
  - DE, h_sync and v_sync are registers loaded from the decode of the next x/y values, so they are always consistent with the current x/y (zero skew, no combinational glitch).
  - h_sync = 0 iff HS_START <= x < HS_END.
  - v_sync = 0 iff VS_START <= y < VS_END.
- frame_start:
  - Registered; high for exactly one clk, on the cycle in which x=0 and y=0 first become visible.
  - That cycle is the clk after the wrap edge, with div_cnt=0.
- Reset state (asserted, and immediately after release):
  - div_cnt=0, pixel_tick=0 (1 when CLK_DIV=1)
  - x=H_TOTAL-1 (799), y=V_TOTAL-1 (524)
  - DE=0, h_sync=1, v_sync=1, frame_start=0
  - The first pixel_tick after release therefore steps to (0,0) and starts a clean frame.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous), regardless of counter position. No partial line is completed.
- Latency:
  - The first pixel_tick occurs on clk cycle CLK_DIV-1 after release (cycle 3 for the default).
  - x=0, y=0, DE=1 and frame_start=1 appear on the next cycle.
- Boundary conditions:
  - Line wrap and frame wrap occur on the same edge at (799,524); both are handled in that single update.
  - DE drops on the edge x goes 639->640 and rises on 799->0 only when the new y < V_ACTIVE.
  - Lines 480..524 have DE=0 for every x.
- Timing per frame:
  - Line period is H_TOTAL*CLK_DIV clk (3200).
  - Frame period is V_TOTAL*H_TOTAL*CLK_DIV clk (1,680,000).

Test Plan:
- Reset hold then release, default params -> during reset x=799, y=524, DE=0, h_sync=v_sync=1. pixel_tick first high 3 clks after release. Next clk: x=0, y=0, DE=1, frame_start=1 for exactly 1 clk.
- Run one line -> pixel_tick period 4 clk. h_sync low for exactly 96 ticks (x=656..751). DE high for exactly 640 consecutive ticks. x wraps 799->0 with y incrementing once.
- Run one full frame -> v_sync low for exactly 2 lines (y=490,491 = 1600 ticks). DE-high count = 307200. frame_start pulses once per 1,680,000 clk. y wraps 524->0 on the same edge as x 799->0.
- Assert reset at x=300, y=200 for 2 clk -> outputs return to the reset values within the same cycle. After release the bench sees a full frame from (0,0) with the latency of the first scenario.
- CLK_DIV=1, small timing (H 8/1/2/1, V 4/1/1/1) -> pixel_tick constantly 1. Line = 12 clk, frame = 84 clk. h_sync low at x=9,10. v_sync low at y=5. DE pattern exact.
- Scoreboard check on every clk -> DE, h_sync and v_sync always equal the decode of the current x/y. frame_start is never high unless x=0 and y=0.
